// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch driver: FSM state type, default timing
// parameters and a small elaboration-time helper.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } sr_state_t;

    localparam int unsigned SR_PULSE_W_DEF = 2;
    localparam int unsigned SR_GAP_W_DEF   = 1;

    function automatic int unsigned sr_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_timer.sv
// Loadable down-counter with terminal count at 1; holds at zero instead of wrapping.
module sr_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == W'(1));

endmodule

// File: rtl/sr_driver.sv
// Turns valid/ready bit writes into timed, non-overlapping S/R pulses for an SR
// latch, then checks the latch Q feedback against the written value.
module sr_driver
    import sr_pkg::*;
#(
    parameter int unsigned PULSE_W = SR_PULSE_W_DEF,
    parameter int unsigned GAP_W   = SR_GAP_W_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req_valid,
    input  logic req_value,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic q_fb,
    output logic expected,
    output logic done,
    output logic err,
    input  logic err_clr
);

    localparam int unsigned TW = $clog2(sr_max(PULSE_W, GAP_W) + 1);

    sr_state_t      state, state_n;
    logic           target, target_n;
    logic           known;
    logic           accept, skip;
    logic           tload;
    logic [TW-1:0]  tval;
    logic           tc;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign skip      = accept && known && (req_value == expected);

    sr_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (tload),
        .load_val (tval),
        .tc       (tc)
    );

    always_comb begin
        state_n  = state;
        target_n = target;
        tload    = 1'b0;
        tval     = '0;
        case (state)
            IDLE: begin
                if (accept && !skip) begin
                    state_n  = PULSE;
                    target_n = req_value;
                    tload    = 1'b1;
                    tval     = TW'(PULSE_W);
                end
            end
            PULSE: begin
                if (tc) begin
                    state_n = GAP;
                    tload   = 1'b1;
                    tval    = TW'(GAP_W);
                end
            end
            GAP: begin
                if (tc) state_n = CHECK;
            end
            CHECK: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // S/R come from next state so they are registered and can never overlap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            target   <= 1'b0;
            known    <= 1'b0;
            expected <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state  <= state_n;
            target <= target_n;
            S      <= (state_n == PULSE) && target_n;
            R      <= (state_n == PULSE) && !target_n;
            done   <= skip || (state == CHECK);
            if (state == CHECK) begin
                expected <= target;
                known    <= 1'b1;
            end
            // A mismatch at check time outranks a simultaneous clear.
            if ((state == CHECK) && (q_fb != target)) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sr_driver.sv
// Scoreboard bench for sr_driver: a high-level write model predicts each completion,
// a monitor compares it when done fires; the latch is emulated from S/R.
module tb_sr_driver;

    localparam int unsigned PW = 2;
    localparam int unsigned GW = 1;

    logic clock, reset_n, req_valid, req_value, req_ready;
    logic S, R, q_fb, expected, done, err, err_clr;

    typedef struct {
        bit          value;
        bit          skip;
        bit          err;
        int unsigned acc;
    } item_t;

    typedef struct {
        int unsigned cyc;
        bit          skip;
    } acc_t;

    item_t       sbq[$];
    acc_t        acc_log[$];
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          known_m = 0, exp_m = 0, err_m = 0;
    int          q_mode = 0;   // 0: latch follows S/R, 1: stuck at 0, 2: stuck at 1
    logic        qlat;

    sr_driver #(.PULSE_W(PW), .GAP_W(GW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_value (req_value),
        .req_ready (req_ready),
        .S         (S),
        .R         (R),
        .q_fb      (q_fb),
        .expected  (expected),
        .done      (done),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)  qlat <= 1'b0;
        else if (S)    qlat <= 1'b1;
        else if (R)    qlat <= 1'b0;
    end

    assign q_fb = (q_mode == 0) ? qlat : (q_mode == 2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a write is skipped only when the driver already knows Q equals it.
    always @(negedge clock) begin
        if (reset_n && req_valid && req_ready) begin
            item_t it;
            bit    mism;
            it.value = req_value;
            it.skip  = known_m && (req_value == exp_m);
            mism     = !it.skip && (((q_mode == 1) && req_value) || ((q_mode == 2) && !req_value));
            if (mism) err_m = 1'b1;
            it.err   = err_m;
            it.acc   = cyc;
            exp_m    = req_value;
            known_m  = 1'b1;
            sbq.push_back(it);
            acc_log.push_back('{cyc: cyc, skip: it.skip});
        end
    end

    int unsigned scnt = 0, rcnt = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            scnt = 0;
            rcnt = 0;
        end else begin
            check("s_and_r", {31'd0, S && R}, 32'd0);
            if (done) begin
                if (sbq.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    item_t it;
                    it = sbq.pop_front();
                    check("done_expected", {31'd0, expected}, {31'd0, it.value});
                    check("done_err", {31'd0, err}, {31'd0, it.err});
                    check("latency", cyc - it.acc, it.skip ? 32'd1 : PW + GW + 2);
                    check("s_cycles", scnt, (!it.skip && it.value) ? PW : 32'd0);
                    check("r_cycles", rcnt, (!it.skip && !it.value) ? PW : 32'd0);
                end
                scnt = 0;
                rcnt = 0;
            end
            if (S) scnt++;
            if (R) rcnt++;
        end
    end

    // All tasks start and end #1 after a rising edge.
    task automatic issue(input bit v);
        int unsigned n = 0;
        req_valid = 1'b1;
        req_value = v;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready && n < 50);
        if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sbq.size() != 0 || !req_ready) && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("idle_wait", {31'd0, n < 40}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clock);
        #1 err_clr = 1'b0;
        err_m = 1'b0;
    endtask

    task automatic model_reset();
        sbq.delete();
        known_m = 1'b0;
        exp_m   = 1'b0;
        err_m   = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_value = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_s", {31'd0, S}, 32'd0);
        check("rst_r", {31'd0, R}, 32'd0);
        check("rst_expected", {31'd0, expected}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);

        // First write always pulses, even though expected already reads 0.
        issue(1'b0);
        wait_idle();
        issue(1'b1);
        wait_idle();
        check("w1_expected", {31'd0, expected}, 32'd1);
        check("w1_err", {31'd0, err}, 32'd0);
        issue(1'b0);
        wait_idle();
        check("w0_expected", {31'd0, expected}, 32'd0);

        // Skip path, single then back-to-back.
        issue(1'b1);
        wait_idle();
        issue(1'b1);
        check("skip_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_value = 1'b1;
        repeat (3) @(posedge clock);
        #1 req_valid = 1'b0;
        check("skip_b2b_ready", {31'd0, req_ready}, 32'd1);
        wait_idle();

        // Stuck-at-0 latch: mismatch, clear, then clear racing a new mismatch.
        q_mode = 1;
        issue(1'b0);
        wait_idle();
        issue(1'b1);
        wait_idle();
        check("mm_err", {31'd0, err}, 32'd1);
        check("mm_expected", {31'd0, expected}, 32'd1);
        pulse_clr();
        check("clr_err", {31'd0, err}, 32'd0);
        issue(1'b0);
        wait_idle();
        issue(1'b1);
        repeat (3) @(posedge clock);
        #1 err_clr = 1'b1;
        @(posedge clock);
        #1 err_clr = 1'b0;
        wait_idle();
        check("clr_vs_set_err", {31'd0, err}, 32'd1);

        // Reset during the pulse.
        q_mode = 0;
        pulse_clr();
        issue(1'b0);
        check("pre_rst_r", {31'd0, R}, 32'd1);
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_s", {31'd0, S}, 32'd0);
        check("async_rst_r", {31'd0, R}, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        check("post_rst_expected", {31'd0, expected}, 32'd0);
        issue(1'b0);
        wait_idle();
        issue(1'b1);
        wait_idle();

        // Valid held high with req_value toggling every cycle.
        acc_log.delete();
        req_valid = 1'b1;
        req_value = 1'b0;
        repeat (22) begin
            @(posedge clock);
            #1 req_value = ~req_value;
        end
        req_valid = 1'b0;
        wait_idle();
        check("hold_accepts", {31'd0, acc_log.size() >= 4}, 32'd1);
        for (int i = 1; i < acc_log.size(); i++) begin
            check("hold_interval", acc_log[i].cyc - acc_log[i-1].cyc,
                  acc_log[i-1].skip ? 32'd1 : PW + GW + 2);
        end

        // Randomized run.
        for (int i = 0; i < 200; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                wait_idle();
                q_mode = int'($urandom_range(0, 2));
            end else if (r == 2) begin
                wait_idle();
                pulse_clr();
                check("rand_clr_err", {31'd0, err}, 32'd0);
            end
            issue(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
            end else begin
                repeat ($urandom_range(0, 3)) @(posedge clock);
                #1;
            end
        end
        wait_idle();
        check("drain", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
